// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch/decode constants
// NOP encoding, fetch FSM state encodings and a PC alignment helper.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_RUN   = 2'd1,
    F_DRAIN = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory request/response bus
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;

  logic        f_out_imem_req;
  logic [31:0] f_out_imem_addr;
  logic        f_in_imem_gnt;
  logic        f_in_imem_rvalid;
  logic [31:0] f_in_imem_rdata;

  modport master (
    output f_out_imem_req,
    output f_out_imem_addr,
    input  f_in_imem_gnt,
    input  f_in_imem_rvalid,
    input  f_in_imem_rdata
  );

  modport slave (
    input  f_out_imem_req,
    input  f_out_imem_addr,
    output f_in_imem_gnt,
    output f_in_imem_rvalid,
    output f_in_imem_rdata
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO with flush
// Head is presented combinationally; push into a full FIFO and pop of an empty one are ignored.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    do_pop   = pop && (count_q != '0);
    do_push  = push && (count_q != (AW+1)'(DEPTH));
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - in-order instruction fetch with redirect flush and credit-based issue
// FETCH_PERF_CNT_EN adds saturating fetched-word and kill-cycle counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          CNT_W      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_stage_if.master        imem,
  input  logic                 f_in_stall,
  input  logic                 f_in_redirect,
  input  logic [31:0]          f_in_redirect_pc,
  output logic [31:0]          f_out_instr,
  output logic [31:0]          f_out_pc,
  output logic                 f_out_kill_instr
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          f_out_perf_fetched,
  output logic [31:0]          f_out_perf_killed
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [AW:0]      fifo_count, tag_count;
  logic [AW+1:0]    credits_used;
  logic [63:0]      fifo_head;
  logic [31:0]      tag_head;
  logic             req, issue, rv_keep, rv_drop, push, pop, kill;

  // Tag queue occupancy is exactly outstanding + drop_cnt, so it serves as the credit count.
  always_comb begin
    kill         = (fifo_count == '0) || f_in_redirect;
    pop          = !kill && !f_in_stall;
    credits_used = (AW+2)'(tag_count) + (AW+2)'(fifo_count);
    req          = (state_q != F_IDLE) && !f_in_redirect
                   && (credits_used < (AW+2)'(FIFO_DEPTH));
    issue        = req && imem.f_in_imem_gnt;
    rv_drop      = imem.f_in_imem_rvalid && (drop_q != '0);
    rv_keep      = imem.f_in_imem_rvalid && (drop_q == '0);
    push         = rv_keep && !f_in_redirect;
  end

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    state_d       = state_q;
    if (f_in_redirect) begin
      // Everything still in flight becomes wrong-path; a response landing now is one less to drop.
      pc_d          = word_align(f_in_redirect_pc);
      drop_d        = drop_q - CNT_W'(rv_drop) + outstanding_q - CNT_W'(rv_keep);
      outstanding_d = '0;
    end else begin
      if (issue) begin
        pc_d = pc_q + 32'd4;
      end
      drop_d        = drop_q - CNT_W'(rv_drop);
      outstanding_d = outstanding_q + CNT_W'(issue) - CNT_W'(rv_keep);
    end
    unique case (state_q)
      F_IDLE:  state_d = F_RUN;
      F_RUN:   if (f_in_redirect && (drop_d != '0)) state_d = F_DRAIN;
      F_DRAIN: if (drop_d == '0) state_d = F_RUN;
      default: state_d = F_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= F_IDLE;
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(64)) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({tag_head, imem.f_in_imem_rdata}),
    .pop       (pop),
    .flush     (f_in_redirect),
    .head      (fifo_head),
    .count     (fifo_count)
  );

  // Never flushed: dropped responses still retire their tag.
  fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (issue),
    .push_data (pc_q),
    .pop       (imem.f_in_imem_rvalid),
    .flush     (1'b0),
    .head      (tag_head),
    .count     (tag_count)
  );

  assign imem.f_out_imem_req  = req;
  assign imem.f_out_imem_addr = pc_q;
  assign f_out_kill_instr     = kill;
  assign f_out_instr          = kill ? NOP_INSTR : fifo_head[31:0];
  assign f_out_pc             = kill ? pc_q : fifo_head[63:32];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_killed_q, perf_killed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_killed_d  = perf_killed_q;
    if (push && !(&perf_fetched_q)) perf_fetched_d = perf_fetched_q + 32'd1;
    if (kill && !(&perf_killed_q))  perf_killed_d  = perf_killed_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_killed_q  <= perf_killed_d;
    end
  end

  assign f_out_perf_fetched = perf_fetched_q;
  assign f_out_perf_killed  = perf_killed_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
// FETCH_PERF_CNT_EN enables the perf counter checks.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0, redirect = 1'b0, hi_zero = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] out_instr, out_pc, hi_instr, hi_pc;
  logic        out_kill, hi_kill;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_killed, hi_perf_fetched, hi_perf_killed;
`endif

  fetch_stage_if imem_if ();
  fetch_stage_if hi_if ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .imem(imem_if),
    .f_in_stall(stall), .f_in_redirect(redirect), .f_in_redirect_pc(redirect_pc),
    .f_out_instr(out_instr), .f_out_pc(out_pc), .f_out_kill_instr(out_kill)
`ifdef FETCH_PERF_CNT_EN
    , .f_out_perf_fetched(perf_fetched), .f_out_perf_killed(perf_killed)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2), .CNT_W(2)) u_dut_hi (
    .clk(clk), .rst(rst), .imem(hi_if),
    .f_in_stall(hi_zero), .f_in_redirect(hi_zero), .f_in_redirect_pc(32'h0),
    .f_out_instr(hi_instr), .f_out_pc(hi_pc), .f_out_kill_instr(hi_kill)
`ifdef FETCH_PERF_CNT_EN
    , .f_out_perf_fetched(hi_perf_fetched), .f_out_perf_killed(hi_perf_killed)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory models: grants captured mid-cycle, responses presented in order after lat cycles.
  int          lat  = 1;
  int          tick = 0;
  logic [31:0] pend_addr[$], hi_pend_addr[$], grant_log[$], hi_grant_log[$];
  int          pend_due[$], hi_pend_due[$];

  initial begin
    imem_if.f_in_imem_gnt    = 1'b1;
    imem_if.f_in_imem_rvalid = 1'b0;
    imem_if.f_in_imem_rdata  = '0;
    hi_if.f_in_imem_gnt      = 1'b1;
    hi_if.f_in_imem_rvalid   = 1'b0;
    hi_if.f_in_imem_rdata    = '0;
    forever begin
      @(posedge clk);
      #1;
      tick++;
      imem_if.f_in_imem_rvalid = 1'b0;
      hi_if.f_in_imem_rvalid   = 1'b0;
      if (rst) begin
        pend_addr.delete(); pend_due.delete(); grant_log.delete();
        hi_pend_addr.delete(); hi_pend_due.delete(); hi_grant_log.delete();
      end else begin
        if (pend_due.size() > 0 && pend_due[0] <= tick) begin
          imem_if.f_in_imem_rvalid = 1'b1;
          imem_if.f_in_imem_rdata  = mem_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (hi_pend_due.size() > 0 && hi_pend_due[0] <= tick) begin
          hi_if.f_in_imem_rvalid = 1'b1;
          hi_if.f_in_imem_rdata  = mem_word(hi_pend_addr.pop_front());
          void'(hi_pend_due.pop_front());
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && imem_if.f_out_imem_req && imem_if.f_in_imem_gnt) begin
      pend_addr.push_back(imem_if.f_out_imem_addr);
      pend_due.push_back(tick + lat);
      grant_log.push_back(imem_if.f_out_imem_addr);
    end
    if (!rst && hi_if.f_out_imem_req && hi_if.f_in_imem_gnt) begin
      hi_pend_addr.push_back(hi_if.f_out_imem_addr);
      hi_pend_due.push_back(tick + 1);
      hi_grant_log.push_back(hi_if.f_out_imem_addr);
    end
  end

  // Scoreboard monitor
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];
  int   kill_cycles = 0;
  int   delivered   = 0;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      kill_cycles = 0;
      delivered   = 0;
    end else if (out_kill) begin
      kill_cycles++;
      check("kill_nop", out_instr, NOP_INSTR);
    end else if (!stall) begin
      delivered++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
      end
    end
  end

  task automatic push_exp(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.pc    = base + 32'(4 * i);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench in the cycle right after reset release.
  task automatic do_reset(input int l);
    step();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_if.f_in_imem_gnt = 1'b1;
    lat = l;
    exp_q.delete();
    step();
    step();
    @(negedge clk);
    check("rst_req", {31'd0, imem_if.f_out_imem_req}, 32'd0);
    check("rst_kill", {31'd0, out_kill}, 32'd1);
    check("rst_instr", out_instr, NOP_INSTR);
    check("rst_pc", out_pc, 32'h0000_0000);
    check("rst_hi_pc", hi_pc, 32'hFFFF_FFF8);
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d words pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_grant(input string name, input int idx, input logic [31:0] exp);
    if (grant_log.size() > idx) check(name, grant_log[idx], exp);
    else check(name, 32'hBAD0_BAD0, exp);
  endtask

  initial begin
    // 1: straight-line fetch, 1-cycle memory
    do_reset(1);
    push_exp(32'h0, 8);
    @(negedge clk);
    check("idle_req", {31'd0, imem_if.f_out_imem_req}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("first_kill", {31'd0, out_kill}, (k < 3) ? 32'd1 : 32'd0);
    end
    wait_drain("t1");

    // 5: RESET_PC near the top of the address space wraps to 0
    if (hi_grant_log.size() >= 3) begin
      check("wrap_a0", hi_grant_log[0], 32'hFFFF_FFF8);
      check("wrap_a1", hi_grant_log[1], 32'hFFFF_FFFC);
      check("wrap_a2", hi_grant_log[2], 32'h0000_0000);
    end else begin
      check("wrap_cnt", hi_grant_log.size(), 32'd3);
    end

    // 2: stall with full FIFO
    do_reset(1);
    stall = 1'b1;
    push_exp(32'h0, 6);
    repeat (5) step();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_req", {31'd0, imem_if.f_out_imem_req}, 32'd0);
      check("stall_kill", {31'd0, out_kill}, 32'd0);
      check("stall_pc", out_pc, 32'h0);
      check("stall_instr", out_instr, mem_word(32'h0));
    end
    step();
    stall = 1'b0;
    wait_drain("t2");

    // 3: redirect to unaligned target with two requests outstanding
    do_reset(3);
    push_exp(32'h100, 4);
    step(); step(); step();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    wait_drain("t3");
    check_grant("t3_addr", 2, 32'h100);

    // 4: redirect together with rvalid, then a second redirect while draining
    do_reset(3);
    push_exp(32'h300, 4);
    step();
    step(); imem_if.f_in_imem_gnt = 1'b0;
    step(); imem_if.f_in_imem_gnt = 1'b1;
    step(); redirect = 1'b1; redirect_pc = 32'h200;
    step(); redirect = 1'b0;
    step(); redirect = 1'b1; redirect_pc = 32'h300;
    step(); redirect = 1'b0;
    wait_drain("t4");
    check_grant("t4_drain_addr", 2, 32'h200);
    check_grant("t4_final_addr", 3, 32'h300);

`ifdef FETCH_PERF_CNT_EN
    // 6: counters after 10 deliveries, then FIFO left full under stall
    do_reset(1);
    push_exp(32'h0, 10);
    wait_drain("t6");
    stall = 1'b1;
    repeat (8) step();
    check("perf_fetched", perf_fetched, 32'(delivered + 2));
    check("perf_killed", perf_killed, 32'(kill_cycles));
    stall = 1'b0;
`endif

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
